// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb: FIR XIFU writeback stage with commit tracking, regfile write and XIF result retirement
package fir_xifu_pkg;
  localparam int X_ID_WIDTH = 4;
  typedef enum logic [1:0] {
    INSTR_INVALID,
    INSTR_XFIRLW,
    INSTR_XFIRSW,
    INSTR_XFIRDOTP
  } fir_xifu_instr_t;
  typedef struct packed {
    fir_xifu_instr_t       instr;
    logic [31:0]           result;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [X_ID_WIDTH-1:0] id;
  } fir_xifu_ex2wb_t;
  typedef struct packed {
    logic        write;
    logic [4:0]  rd;
    logic [31:0] result;
  } fir_xifu_wb2regfile_t;
endpackage

module fir_xifu_wb #(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                ex_valid_i,
  output logic                                ex_ready_o,
  input  fir_xifu_pkg::fir_xifu_ex2wb_t       ex2wb_i,
  input  logic                                mem_result_valid_i,
  input  logic [X_ID_WIDTH-1:0]               mem_result_id_i,
  input  logic [31:0]                         mem_result_rdata_i,
  input  logic                                commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]               commit_id_i,
  input  logic                                commit_kill_i,
  output fir_xifu_pkg::fir_xifu_wb2regfile_t  wb2regfile_o,
  output logic                                result_valid_o,
  input  logic                                result_ready_i,
  output logic [X_ID_WIDTH-1:0]               result_id_o,
  output logic [31:0]                         result_data_o,
  output logic                                result_we_o
);
  localparam int DEPTH = 1 << X_ID_WIDTH;

  typedef enum logic [1:0] {EMPTY, WAIT_MEM, WAIT_COMMIT, RESULT} state_t;

  state_t                        state, state_n;
  fir_xifu_pkg::fir_xifu_instr_t instr;
  logic [31:0]                   result;
  logic [4:0]                    rs1, rs2, rd;
  logic [X_ID_WIDTH-1:0]         id;
  logic [DEPTH-1:0]              committed, killed;
  logic                          fwd, decided, kill, accept, mem_hit;
  logic                          write, clear, capture, load;
  logic                          unused_rs;

  // rs1/rs2 are held for future hazard reporting only
  assign unused_rs = ^{rs1, rs2};

  assign fwd     = commit_valid_i && commit_id_i == id;
  assign decided = fwd || committed[id];
  assign kill    = fwd ? commit_kill_i : killed[id];
  assign accept  = ex_valid_i && ex2wb_i.instr != fir_xifu_pkg::INSTR_INVALID;
  assign mem_hit = mem_result_valid_i && mem_result_id_i == id;

  assign wb2regfile_o  = '{write: write, rd: rd, result: result};
  assign result_id_o   = id;
  assign result_data_o = '0;
  assign result_we_o   = 1'b0;

  // Next-state and handshake control for the single holding entry
  always_comb begin
    state_n        = state;
    ex_ready_o     = 1'b0;
    result_valid_o = 1'b0;
    write          = 1'b0;
    clear          = 1'b0;
    capture        = 1'b0;
    load           = 1'b0;
    case (state)
      EMPTY: begin
        ex_ready_o = 1'b1;
        capture    = accept;
        if (accept)
          state_n = (ex2wb_i.instr == fir_xifu_pkg::INSTR_XFIRLW) ? WAIT_MEM : WAIT_COMMIT;
      end
      WAIT_MEM: begin
        load = mem_hit;
        if (mem_hit) state_n = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (decided) begin
          clear   = kill;
          write   = !kill && (instr == fir_xifu_pkg::INSTR_XFIRLW || instr == fir_xifu_pkg::INSTR_XFIRDOTP);
          state_n = kill ? EMPTY : RESULT;
        end
      end
      RESULT: begin
        result_valid_o = 1'b1;
        clear          = result_ready_i;
        if (result_ready_i) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_n;
  end

  // Holding entry: captured from execute, result replaced by load data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr  <= fir_xifu_pkg::INSTR_INVALID;
      result <= '0;
      rs1    <= '0;
      rs2    <= '0;
      rd     <= '0;
      id     <= '0;
    end else if (capture) begin
      instr  <= ex2wb_i.instr;
      result <= ex2wb_i.result;
      rs1    <= ex2wb_i.rs1;
      rs2    <= ex2wb_i.rs2;
      rd     <= ex2wb_i.rd;
      id     <= X_ID_WIDTH'(ex2wb_i.id);
    end else if (load) begin
      result <= mem_result_rdata_i;
    end
  end

  // Commit table: a same-cycle set overrides the clear of the held ID
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      committed <= '0;
      killed    <= '0;
    end else begin
      if (clear) begin
        committed[id] <= 1'b0;
        killed[id]    <= 1'b0;
      end
      if (commit_valid_i) begin
        committed[commit_id_i] <= 1'b1;
        killed[commit_id_i]    <= commit_kill_i;
      end
    end
  end
endmodule

// File: tb/tb_fir_xifu_wb.sv
// tb_fir_xifu_wb: directed and randomized checks of fir_xifu_wb against a behavioural model
module tb_fir_xifu_wb;
  import fir_xifu_pkg::*;
  localparam int W = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 ex_valid_i, ex_ready_o;
  fir_xifu_ex2wb_t      ex2wb_i;
  logic                 mem_result_valid_i;
  logic [W-1:0]         mem_result_id_i;
  logic [31:0]          mem_result_rdata_i;
  logic                 commit_valid_i, commit_kill_i;
  logic [W-1:0]         commit_id_i;
  fir_xifu_wb2regfile_t wb2regfile_o;
  logic                 result_valid_o, result_ready_i, result_we_o;
  logic [W-1:0]         result_id_o;
  logic [31:0]          result_data_o;

  always #5 clk_i = ~clk_i;

  fir_xifu_wb #(.X_ID_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex2wb_i(ex2wb_i),
    .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
    .mem_result_rdata_i(mem_result_rdata_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .wb2regfile_o(wb2regfile_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one pending instruction, waiting on memory, then on a decision, then offered
  bit              m_init = 0, m_has = 0, m_mem = 0, m_offer = 0;
  fir_xifu_ex2wb_t m_rec = '0;
  bit [15:0]       m_com = '0, m_kil = '0;

  function automatic void decide(output bit dec, output bit kl);
    bit fwd;
    fwd = commit_valid_i && commit_id_i == m_rec.id;
    dec = m_has && !m_mem && !m_offer && (fwd || m_com[m_rec.id]);
    kl  = fwd ? commit_kill_i : m_kil[m_rec.id];
  endfunction

  always @(posedge clk_i) begin
    bit dec, kl;
    if (!rst_ni) begin
      m_init = 1; m_has = 0; m_mem = 0; m_offer = 0; m_rec = '0; m_com = '0; m_kil = '0;
    end else if (m_init) begin
      decide(dec, kl);
      if ((dec && kl) || (m_offer && result_ready_i)) begin
        m_com[m_rec.id] = 0;
        m_kil[m_rec.id] = 0;
      end
      if (commit_valid_i) begin
        m_com[commit_id_i] = 1;
        m_kil[commit_id_i] = commit_kill_i;
      end
      if (!m_has) begin
        if (ex_valid_i && ex2wb_i.instr != INSTR_INVALID) begin
          m_has = 1; m_rec = ex2wb_i; m_mem = ex2wb_i.instr == INSTR_XFIRLW; m_offer = 0;
        end
      end else if (m_mem) begin
        if (mem_result_valid_i && mem_result_id_i == m_rec.id) begin
          m_rec.result = mem_result_rdata_i; m_mem = 0;
        end
      end else if (!m_offer) begin
        if (dec) begin
          if (kl) m_has = 0;
          else    m_offer = 1;
        end
      end else if (result_ready_i) begin
        m_has = 0; m_offer = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    bit dec, kl;
    if (m_init) begin
      decide(dec, kl);
      chk("m_ex_ready", ex_ready_o, !m_has);
      chk("m_write", wb2regfile_o.write, dec && !kl && m_rec.instr inside {INSTR_XFIRLW, INSTR_XFIRDOTP});
      chk("m_wb_rd", wb2regfile_o.rd, m_rec.rd);
      chk("m_wb_result", wb2regfile_o.result, m_rec.result);
      chk("m_result_valid", result_valid_o, m_offer);
      if (m_offer) chk("m_result_id", result_id_o, m_rec.id);
      chk("m_result_data", result_data_o, 0);
      chk("m_result_we", result_we_o, 0);
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input fir_xifu_instr_t ins, input int id, input int rd, input logic [31:0] res);
    ex_valid_i = 1;
    ex2wb_i = '{instr: ins, result: res, rs1: 5'd1, rs2: 5'd2, rd: 5'(rd), id: 4'(id)};
  endtask

  task automatic commit(input int id, input bit kill);
    commit_valid_i = 1;
    commit_id_i = W'(id);
    commit_kill_i = kill;
  endtask

  initial begin
    ex_valid_i = 0; ex2wb_i = '0;
    mem_result_valid_i = 0; mem_result_id_i = '0; mem_result_rdata_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0; result_ready_i = 0;
    tick; tick; rst_ni = 1;
    @(negedge clk_i);
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_wb", wb2regfile_o, 0);

    // DOTP with commit one cycle ahead
    tick; commit(3, 0);
    tick; commit_valid_i = 0; send(INSTR_XFIRDOTP, 3, 5, 32'h1234);
    tick; ex_valid_i = 0;
    @(negedge clk_i);
    chk("dotp_write", wb2regfile_o.write, 1);
    chk("dotp_rd", wb2regfile_o.rd, 5);
    chk("dotp_res", wb2regfile_o.result, 32'h1234);
    chk("dotp_nvalid", result_valid_o, 0);
    tick; result_ready_i = 1;
    @(negedge clk_i);
    chk("dotp_write_once", wb2regfile_o.write, 0);
    chk("dotp_valid", result_valid_o, 1);
    chk("dotp_id", result_id_o, 3);
    chk("dotp_we", result_we_o, 0);
    tick; result_ready_i = 0;
    @(negedge clk_i);
    chk("dotp_ready_back", ex_ready_o, 1);

    // LW with a stray response, then a late forwarded commit
    tick; send(INSTR_XFIRLW, 7, 2, 32'h0);
    tick; ex_valid_i = 0; mem_result_valid_i = 1; mem_result_id_i = 2; mem_result_rdata_i = 32'h1111_1111;
    tick; mem_result_id_i = 7; mem_result_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("lw_ignore_id2", wb2regfile_o.result, 0);
    tick; mem_result_valid_i = 0;
    @(negedge clk_i);
    chk("lw_loaded", wb2regfile_o.result, 32'hDEAD_BEEF);
    repeat (2) begin
      tick;
      @(negedge clk_i);
      chk("lw_nowrite", wb2regfile_o.write, 0);
    end
    tick; commit(7, 0);
    @(negedge clk_i);
    chk("lw_write", wb2regfile_o.write, 1);
    chk("lw_res", wb2regfile_o.result, 32'hDEAD_BEEF);
    chk("lw_rd", wb2regfile_o.rd, 2);
    tick; commit_valid_i = 0; result_ready_i = 1;
    @(negedge clk_i);
    chk("lw_id", result_id_o, 7);
    tick; result_ready_i = 0;

    // SW never writes
    tick; send(INSTR_XFIRSW, 1, 9, 32'h55);
    tick; ex_valid_i = 0; commit(1, 0);
    @(negedge clk_i);
    chk("sw_nowrite", wb2regfile_o.write, 0);
    tick; commit_valid_i = 0; result_ready_i = 1;
    @(negedge clk_i);
    chk("sw_valid", result_valid_o, 1);
    chk("sw_id", result_id_o, 1);
    chk("sw_busy", ex_ready_o, 0);
    tick; result_ready_i = 0;
    @(negedge clk_i);
    chk("sw_ready", ex_ready_o, 1);

    // Killed DOTP, then the same ID reused
    tick; commit(4, 1);
    tick; commit_valid_i = 0; send(INSTR_XFIRDOTP, 4, 6, 32'hABC);
    tick; ex_valid_i = 0;
    @(negedge clk_i);
    chk("kill_nowrite", wb2regfile_o.write, 0);
    tick;
    @(negedge clk_i);
    chk("kill_empty", ex_ready_o, 1);
    chk("kill_novalid", result_valid_o, 0);
    tick; send(INSTR_XFIRDOTP, 4, 6, 32'hABC);
    tick; ex_valid_i = 0;
    @(negedge clk_i);
    chk("reuse_wait", wb2regfile_o.write, 0);
    tick; commit(4, 0);
    @(negedge clk_i);
    chk("reuse_write", wb2regfile_o.write, 1);
    tick; commit_valid_i = 0; result_ready_i = 1;
    @(negedge clk_i);
    chk("reuse_id", result_id_o, 4);
    tick; result_ready_i = 0;

    // Back-pressure on the result
    tick; commit(5, 0);
    tick; commit_valid_i = 0; send(INSTR_XFIRDOTP, 5, 1, 32'h77);
    tick; ex_valid_i = 0;
    repeat (5) begin
      tick;
      @(negedge clk_i);
      chk("stall_valid", result_valid_o, 1);
      chk("stall_id", result_id_o, 5);
      chk("stall_busy", ex_ready_o, 0);
    end
    result_ready_i = 1;
    tick; result_ready_i = 0;

    // Reset while waiting on memory
    tick; send(INSTR_XFIRLW, 8, 3, 32'h9);
    tick; ex_valid_i = 0; rst_ni = 0;
    tick; rst_ni = 1;
    @(negedge clk_i);
    chk("rst2_valid", result_valid_o, 0);
    chk("rst2_wb", wb2regfile_o, 0);
    chk("rst2_ready", ex_ready_o, 1);

    // Randomized traffic; the model process checks every cycle
    for (int i = 0; i < 4000; i++) begin
      tick;
      rst_ni = $urandom_range(199) != 0;
      ex_valid_i = $urandom_range(1);
      ex2wb_i = '{instr: fir_xifu_instr_t'($urandom_range(3)), result: $urandom,
                  rs1: 5'($urandom), rs2: 5'($urandom), rd: 5'($urandom), id: 4'($urandom_range(7))};
      mem_result_valid_i = $urandom_range(2) == 0;
      mem_result_id_i = W'($urandom_range(7));
      mem_result_rdata_i = $urandom;
      commit_valid_i = $urandom_range(4) == 0;
      commit_id_i = W'($urandom_range(7));
      commit_kill_i = $urandom_range(3) == 0;
      result_ready_i = $urandom_range(1);
    end
    tick;
    rst_ni = 1; ex_valid_i = 0; mem_result_valid_i = 0; commit_valid_i = 0; result_ready_i = 0;
    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
